multi_debouncer: RTL and testbench

- Parametrised N-channel successor to the single-button debouncer, for all crane-game inputs (joystick directions, drop, coin).
- Per-channel synchroniser, then a stability counter driven by one shared sample tick. A channel's debounced level changes only after STABLE_CNT consecutive agreeing samples.
- Emits the clean level plus one-clock rise and fall pulses per channel.
- Sits between the board pins and the game FSM.

---
 rtl/multi_debouncer.sv | 133 +++++++++++++
 tb/tb_multi_debouncer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// N-channel debouncer: per-channel synchroniser plus tick-driven stability counter.
// Optional auto-repeat on held channels when MULTI_DEBOUNCER_AUTOREPEAT_EN is defined.
module multi_debouncer #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 250000,
  parameter int STABLE_CNT   = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int REPEAT_DELAY = 100,
  parameter int REPEAT_RATE  = 25
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [N_CH-1:0] signal_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            tick_out
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
  // An illegal parameter set never ticks, so every level stays at its reset value.
  localparam bit P_LEGAL = (TICK_DIV >= 2) && (STABLE_CNT >= 1) && (SYNC_STAGES >= 2) &&
                           (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);

  logic [TW-1:0]                   r_tick_cnt;
  logic                            r_tick;
  logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync;
  logic [N_CH-1:0][SW-1:0]         r_cnt;
  logic [N_CH-1:0]                 r_level;
  logic [N_CH-1:0]                 r_rise;
  logic [N_CH-1:0]                 r_fall;
  logic [N_CH-1:0]                 w_sync;
  logic [N_CH-1:0]                 w_flip;
  logic [N_CH-1:0]                 w_rep_fire;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick     <= P_LEGAL && (r_tick_cnt == TICK_LAST);
      r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], signal_in};
    end
  end

  // Channels whose level flips on this clock's edge.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_flip[i] = r_tick && (w_sync[i] != r_level[i]) && (r_cnt[i] == STABLE_LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_rise <= w_rep_fire;
      r_fall <= '0;
      if (r_tick) begin
        for (int i = 0; i < N_CH; i++) begin
          if (w_sync[i] == r_level[i]) begin
            r_cnt[i] <= '0;
          end else if (w_flip[i]) begin
            r_cnt[i]   <= '0;
            r_level[i] <= w_sync[i];
            if (w_sync[i]) r_rise[i] <= 1'b1;
            else           r_fall[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] + SW'(1);
          end
        end
      end
    end
  end

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] REP_DELAY_V = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RATE_V  = RW'(REPEAT_RATE);

  logic [N_CH-1:0][RW-1:0] r_rep;

  // Down-counter per channel; reaching 1 on a tick fires a repeat and reloads the rate.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_rep <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_flip[i] && w_sync[i]) begin
          r_rep[i] <= REP_DELAY_V;
        end else if (!r_level[i] || w_flip[i]) begin
          r_rep[i] <= '0;
        end else if (r_tick) begin
          r_rep[i] <= (r_rep[i] == RW'(1)) ? REP_RATE_V : r_rep[i] - RW'(1);
        end
      end
    end
  end

  always_comb begin
    w_rep_fire = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_rep_fire[i] = r_tick && r_level[i] && !w_flip[i] && (r_rep[i] == RW'(1));
    end
  end
`else
  assign w_rep_fire = '0;
`endif

  assign level_out  = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign tick_out   = r_tick;

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: stimulus queues expected pulse events,
// a negedge monitor pops and compares them whenever a pulse is presented.
module tb_multi_debouncer;

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] level;
    int         tick;
  } exp_t;

  logic       clock;
  logic       resetn;
  logic [3:0] signal_in;
  logic [3:0] level_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic       tick_out;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mon_ticks = 0;
  int   stim_ticks = 0;

  multi_debouncer #(
    .N_CH(4), .TICK_DIV(4), .STABLE_CNT(3), .SYNC_STAGES(2),
    .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clock(clock), .resetn(resetn), .signal_in(signal_in),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .tick_out(tick_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [3:0] r, input logic [3:0] f, input logic [3:0] l, input int t);
    exp_t e;
    e.rise = r; e.fall = f; e.level = l; e.tick = t;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clock);
    if (tick_out === 1'b1) stim_ticks++;
  endtask

  task automatic wait_ticks(input int n);
    int budget;
    budget = 400;
    while (stim_ticks < n && budget > 0) begin
      step();
      budget--;
    end
    if (stim_ticks < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_wait: got %0d ticks, expected %0d", stim_ticks, n);
    end
  endtask

  // Monitor: every presented pulse must match the next queued event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetn !== 1'b1) begin
        mon_ticks = 0;
      end else begin
        if (tick_out === 1'b1) mon_ticks++;
        if ((rise_pulse | fall_pulse) != 4'b0) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got rise=%b fall=%b at tick %0d, expected none",
                     rise_pulse, fall_pulse, mon_ticks);
          end else begin
            e = exp_q.pop_front();
            check("pulse_rise",  32'(rise_pulse), 32'(e.rise));
            check("pulse_fall",  32'(fall_pulse), 32'(e.fall));
            check("pulse_level", 32'(level_out),  32'(e.level));
            check("pulse_tick",  32'(mon_ticks),  32'(e.tick));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn    = 1'b0;
    signal_in = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      check("reset_outputs", {19'b0, level_out, rise_pulse, fall_pulse, tick_out}, 32'h0);
    end
    signal_in = 4'h0;
    resetn    = 1'b1;
    stim_ticks = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("tick_period", 32'(tick_out), 32'((k % 4) == 0));
    end

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
    signal_in = 4'b0001;
    push(4'b0001, 4'b0000, 4'b0001, 5);
    push(4'b0001, 4'b0000, 4'b0001, 10);
    push(4'b0001, 4'b0000, 4'b0001, 12);
    push(4'b0001, 4'b0000, 4'b0001, 14);
    push(4'b0001, 4'b0000, 4'b0001, 16);
    push(4'b0000, 4'b0001, 4'b0000, 17);
    wait_ticks(14);
    signal_in = 4'b0000;
    wait_ticks(24);
    check("level_after_release", 32'(level_out), 32'h0);
`else
    // Clean press on ch0, seen from tick 3, flips on tick 5.
    signal_in = 4'b0001;
    push(4'b0001, 4'b0000, 4'b0001, 5);
    wait_ticks(6);
    check("level_clean_press", 32'(level_out), 32'b0001);

    // Bounce on ch1: samples 1,1,0 then held 1 -> flips on tick 12.
    signal_in[1] = 1'b1;
    wait_ticks(8);
    signal_in[1] = 1'b0;
    wait_ticks(9);
    signal_in[1] = 1'b1;
    push(4'b0010, 4'b0000, 4'b0011, 12);
    wait_ticks(11);
    check("level_mid_bounce", 32'(level_out), 32'b0001);
    wait_ticks(13);
    check("level_after_bounce", 32'(level_out), 32'b0011);

    // Glitch on ch2 lasting 6 clocks: only two ticks can see it.
    signal_in[2] = 1'b1;
    for (int k = 0; k < 6; k++) step();
    signal_in[2] = 1'b0;
    wait_ticks(17);
    check("level_after_glitch", 32'(level_out), 32'b0011);

    // ch0 release and ch3 press on the same clock.
    signal_in = 4'b1010;
    push(4'b1000, 4'b0001, 4'b1010, 20);
    wait_ticks(21);
    check("level_simultaneous", 32'(level_out), 32'b1010);

    // Reset during a ch0 debounce abandons it without a pulse.
    signal_in[0] = 1'b1;
    wait_ticks(23);
    resetn    = 1'b0;
    signal_in = 4'h0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("midreset_outputs", {19'b0, level_out, rise_pulse, fall_pulse, tick_out}, 32'h0);
    end
    resetn     = 1'b1;
    stim_ticks = 0;
    wait_ticks(6);
    check("level_after_midreset", 32'(level_out), 32'h0);
`endif

    for (int k = 0; k < 8; k++) step();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
